// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input FIFO feeding a framed serialiser
// (start, LSB-first data, optional parity, 1 or 2 stop bits) with an internal baud divider.
module uart_tx_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 2,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk_sis,
  input  logic                         rst,
  input  logic                         tx_valid,
  input  logic [DATA_W-1:0]            tx_data,
  output logic                         tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         busy,
  output logic                         tx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_W);

  localparam logic [LW-1:0] LvlFull  = LW'(DEPTH);
  localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_par_bit;

  // Serialiser state
  state_e            r_state;
  state_e            w_state_d;
  logic [CW-1:0]     r_baud;
  logic [CW-1:0]     w_baud_d;
  logic [BW-1:0]     r_bit;
  logic [BW-1:0]     w_bit_d;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_d;
  logic              r_parity;
  logic              w_parity_d;
  logic              r_tx;
  logic              w_tx_d;
  logic              w_bit_end;

  assign tx_ready   = (r_level != LvlFull);
  assign w_push     = tx_valid && tx_ready;
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_par_bit  = (PARITY == 1) ? ~(^w_head) : (^w_head);
  assign w_bit_end  = (r_baud == BaudLast);

  assign fifo_level = r_level;
  assign busy       = (r_state != StIdle);
  assign tx         = r_tx;

  always_ff @(posedge clk_sis) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_baud_d   = r_baud;
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_parity_d = r_parity;
    w_pop      = 1'b0;
    w_tx_d     = 1'b1;

    if (r_state != StIdle) begin
      w_baud_d = w_bit_end ? '0 : r_baud + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d = StData;
          w_bit_d   = '0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_shift_d = r_shift >> 1;
          if (r_bit == BitLast) begin
            w_bit_d   = '0;
            w_state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            w_bit_d = r_bit + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_state_d = StStop;
          w_bit_d   = '0;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (r_bit == StopLast) begin
            w_bit_d = '0;
            // Chain straight into the next start bit so queued frames have no idle gap
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_state_d = StStart;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_bit_d = r_bit + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_pop) begin
      w_shift_d  = w_head;
      w_parity_d = w_par_bit;
      w_baud_d   = '0;
      w_bit_d    = '0;
    end

    // Line level is derived from the next state so tx can be a plain register
    unique case (w_state_d)
      StIdle:   w_tx_d = 1'b1;
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
      StParity: w_tx_d = w_parity_d;
      StStop:   w_tx_d = 1'b1;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_baud   <= w_baud_d;
      r_bit    <= w_bit_d;
      r_shift  <= w_shift_d;
      r_parity <= w_parity_d;
      r_tx     <= w_tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations checked every cycle against a frame-level
// model, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v      [4];
  logic [7:0] d      [4];
  logic       rdy_o  [4];
  logic [2:0] lvl_o  [4];
  logic       busy_o [4];
  logic       tx_o   [4];

  // Per-instance configuration: 8E1/4, 8O1/4, 7N2/2, 8N1/4, all DEPTH 4
  int cpb [4] = '{4, 4, 2, 4};
  int dw  [4] = '{8, 8, 7, 8};
  int par [4] = '{2, 1, 0, 0};
  int sb  [4] = '{1, 1, 2, 1};
  int dep [4] = '{4, 4, 4, 4};

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .DEPTH(4)) u_even (
    .clk_sis(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d[0]), .tx_ready(rdy_o[0]),
    .fifo_level(lvl_o[0]), .busy(busy_o[0]), .tx(tx_o[0])
  );
  uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .DEPTH(4)) u_odd (
    .clk_sis(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d[1]), .tx_ready(rdy_o[1]),
    .fifo_level(lvl_o[1]), .busy(busy_o[1]), .tx(tx_o[1])
  );
  uart_tx_param #(.DATA_W(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(2), .DEPTH(4)) u_7n2 (
    .clk_sis(clk), .rst(rst), .tx_valid(v[2]), .tx_data(d[2][6:0]), .tx_ready(rdy_o[2]),
    .fifo_level(lvl_o[2]), .busy(busy_o[2]), .tx(tx_o[2])
  );
  uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .DEPTH(4)) u_8n1 (
    .clk_sis(clk), .rst(rst), .tx_valid(v[3]), .tx_data(d[3]), .tx_ready(rdy_o[3]),
    .fifo_level(lvl_o[3]), .busy(busy_o[3]), .tx(tx_o[3])
  );

  task automatic chk(input string name, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, k, got, exp, $time);
    end
  endtask

  // Frame as a list of bit values, first-on-line at index 0
  function automatic logic [15:0] frame_bits(input int k, input logic [7:0] w);
    logic [15:0] f = '0;
    int          n = 1;
    logic        p = 1'b0;
    for (int i = 0; i < dw[k]; i++) begin
      f[n] = w[i];
      p    = p ^ w[i];
      n++;
    end
    if (par[k] != 0) begin
      f[n] = (par[k] == 1) ? ~p : p;
      n++;
    end
    for (int i = 0; i < sb[k]; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  function automatic int frame_nbits(input int k);
    return 1 + dw[k] + ((par[k] != 0) ? 1 : 0) + sb[k];
  endfunction

  // Model: word queue plus the cycle offset into the frame on the line (-1 = idle)
  int          pos [4] = '{-1, -1, -1, -1};
  logic [15:0] fb  [4];
  logic [7:0]  qd  [4][8];
  int          qh  [4] = '{0, 0, 0, 0};
  int          qn  [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int k = 0; k < 4; k++) begin
        if (!rst) begin
          pos[k] = -1;
          qh[k]  = 0;
          qn[k]  = 0;
        end else begin
          automatic logic pushok = v[k] && (qn[k] != dep[k]);
          if (pos[k] >= 0) begin
            pos[k]++;
            if (pos[k] == frame_nbits(k) * cpb[k]) pos[k] = -1;
          end
          if (pos[k] < 0 && qn[k] > 0) begin
            fb[k]  = frame_bits(k, qd[k][qh[k]]);
            qh[k]  = (qh[k] + 1) % 8;
            qn[k]--;
            pos[k] = 0;
          end
          if (pushok) begin
            qd[k][(qh[k] + qn[k]) % 8] = d[k];
            qn[k]++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 4; k++) begin
          chk("model_tx", k, tx_o[k], (pos[k] < 0) ? 1 : int'(fb[k][pos[k] / cpb[k]]));
          chk("model_busy", k, busy_o[k], (pos[k] >= 0) ? 1 : 0);
          chk("model_level", k, lvl_o[k], qn[k]);
          chk("model_ready", k, rdy_o[k], (qn[k] != dep[k]) ? 1 : 0);
        end
      end
    end
  end

  task automatic frame_test(input int k, input logic [7:0] w, input logic [15:0] exp_bits);
    int          nb = frame_nbits(k);
    int          c  = cpb[k];
    int          busy_cyc = 0;
    logic [15:0] got = '0;
    @(negedge clk);
    v[k] = 1'b1;
    d[k] = w;
    @(negedge clk);
    v[k] = 1'b0;
    chk("accept_level", k, lvl_o[k], 1);
    chk("accept_busy", k, busy_o[k], 0);
    for (int j = 0; j < nb * c + 2 * c; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("start_tx", k, tx_o[k], 0);
        chk("start_busy", k, busy_o[k], 1);
        chk("start_level", k, lvl_o[k], 0);
      end
      if (busy_o[k]) busy_cyc++;
      if (j < nb * c && (j % c) == c / 2) got[j / c] = tx_o[k];
    end
    chk("frame_bits", k, got, exp_bits);
    chk("busy_cycles", k, busy_cyc, nb * c);
    chk("end_tx", k, tx_o[k], 1);
    chk("end_busy", k, busy_o[k], 0);
  endtask

  int   hi3 = 0;
  int   rises3 = 0;
  logic prev3 = 1'b0;

  task automatic step3();
    @(negedge clk);
    if (busy_o[3]) hi3++;
    if (busy_o[3] && !prev3) rises3++;
    prev3 = busy_o[3];
  endtask

  task automatic drain3(input string name);
    int t = 0;
    while (t < 400 && (busy_o[3] || lvl_o[3] != 0)) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle_busy"}, 3, busy_o[3], 0);
    chk({name, "_idle_tx"}, 3, tx_o[3], 1);
  endtask

  initial begin
    int   cur;
    int   maxlvl;
    logic acc;
    logic saw_low;
    logic reasserted;
    int   bad;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v[k] = 1'b0;
      d[k] = 8'h00;
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_tx", k, tx_o[k], 1);
      chk("reset_busy", k, busy_o[k], 0);
      chk("reset_level", k, lvl_o[k], 0);
      chk("reset_ready", k, rdy_o[k], 1);
    end
    // Hand-derived frames pin the model's framing rules
    chk("model_even_5b", 0, frame_bits(0, 8'h5B), 16'h06B6);
    chk("model_odd_5b", 1, frame_bits(1, 8'h5B), 16'h04B6);
    chk("model_7n2_41", 2, frame_bits(2, 8'h41), 16'h0382);
    @(negedge clk);
    rst = 1'b1;

    frame_test(0, 8'h5B, 16'h06B6);
    frame_test(1, 8'h5B, 16'h04B6);
    frame_test(2, 8'h41, 16'h0382);

    // FIFO fill with 0x01..0x06 held valid
    cur = 1; maxlvl = 0; saw_low = 1'b0; reasserted = 1'b0;
    hi3 = 0; rises3 = 0; prev3 = 1'b0;
    step3();
    v[3] = 1'b1;
    d[3] = 8'h01;
    for (int t = 0; t < 400 && cur <= 6; t++) begin
      acc = rdy_o[3];
      step3();
      if (int'(lvl_o[3]) > maxlvl) maxlvl = lvl_o[3];
      if (!rdy_o[3]) saw_low = 1'b1;
      if (saw_low && rdy_o[3] && !reasserted) begin
        reasserted = 1'b1;
        chk("ready_back_start_bit", 3, tx_o[3], 0);
        chk("ready_back_level", 3, lvl_o[3], 3);
      end
      if (acc) begin
        cur++;
        if (cur <= 6) begin
          d[3] = 8'(cur);
        end else begin
          v[3] = 1'b0;
          d[3] = 8'h00;
        end
      end
    end
    chk("fill_max_level", 3, maxlvl, 4);
    chk("fill_ready_dropped", 3, saw_low, 1);
    chk("fill_all_accepted", 3, cur, 7);
    for (int t = 0; t < 400; t++) begin
      step3();
      if (!busy_o[3]) break;
    end
    chk("b2b_busy_cycles", 3, hi3, 240);
    chk("b2b_busy_rises", 3, rises3, 1);
    drain3("fill");

    // Push/pop collision at level 2; pointers wrap past DEPTH here
    @(negedge clk); v[3] = 1'b1; d[3] = 8'h11;
    @(negedge clk); d[3] = 8'h22;
    @(negedge clk); d[3] = 8'h33;
    @(negedge clk); v[3] = 1'b0;
    chk("level_two", 3, lvl_o[3], 2);
    repeat (38) @(negedge clk);
    chk("pre_collision_level", 3, lvl_o[3], 2);
    v[3] = 1'b1;
    d[3] = 8'h44;
    @(negedge clk);
    v[3] = 1'b0;
    chk("collision_level", 3, lvl_o[3], 2);
    chk("collision_start", 3, tx_o[3], 0);
    drain3("wrap");

    // Reset during data bit 3 with two words queued
    @(negedge clk); v[3] = 1'b1; d[3] = 8'h3C;
    @(negedge clk); d[3] = 8'h5A;
    @(negedge clk); d[3] = 8'h69;
    @(negedge clk); v[3] = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset_level", 3, lvl_o[3], 2);
    chk("pre_reset_busy", 3, busy_o[3], 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_tx", 3, tx_o[3], 1);
    chk("async_reset_busy", 3, busy_o[3], 0);
    chk("async_reset_level", 3, lvl_o[3], 0);
    chk("async_reset_ready", 3, rdy_o[3], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (tx_o[3] !== 1'b1 || busy_o[3] !== 1'b0) bad++;
    end
    chk("idle_after_reset", 3, bad, 0);
    frame_test(3, 8'hA5, 16'h034A);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
